// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes, ALU codes,
// the registered decode record and the encoding-legality check.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    CLS_OP         = 3'd0,
    CLS_OP_IMM     = 3'd1,
    CLS_LUI        = 3'd2,
    CLS_AUIPC      = 3'd3,
    CLS_JAL        = 3'd4,
    CLS_JALR       = 3'd5,
    CLS_BRANCH     = 3'd6,
    CLS_LOAD_STORE = 3'd7
  } instr_class_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0]  pc;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  imm;
    logic         alu_imm_en;
    logic [3:0]   operation;
    instr_class_e cls;
    logic         reg_we;
    logic         illegal;
  } decoded_t;

  function automatic logic is_illegal(input logic [31:0] inst);
    logic       bad;
    logic [6:0] funct7;
    logic [2:0] funct3;
    bad    = 1'b0;
    funct7 = inst[31:25];
    funct3 = inst[14:12];
    case (inst[6:0])
      OPC_OP: begin
        if (funct7 == FUNCT7_BASE) begin
          bad = 1'b0;
        end else if (funct7 == FUNCT7_ALT) begin
          bad = (funct3 != 3'b000) && (funct3 != 3'b101);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          bad = (funct7 != FUNCT7_BASE);
        end else if (funct3 == 3'b101) begin
          bad = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
        end else begin
          bad = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: selects the I/S/B/U/J format from
// the opcode and sign-extends from inst[31]; formats without an immediate give 0.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  // format select by opcode
  always_comb begin
    imm_o = 32'd0;
    case (instr_i[6:0])
      OPC_OP_IMM, OPC_JALR, OPC_LOAD:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'd0};
      OPC_JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default:
        imm_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a single-entry valid/ready output register.
// DECODE_ILLEGAL_TRAP_EN: pass illegal encodings downstream flagged; otherwise
// they are replaced by a NOP and illegal_o stays 0.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instruction_i,
  input  logic [31:0] in_pc_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] immediate_data_o,
  output logic        alu_immediate_enable_o,
  output logic [3:0]  operation_o,
  output logic [2:0]  instr_class_o,
  output logic        reg_write_enable_o,
  output logic        illegal_o
);

  logic        raw_illegal;
  logic        dec_illegal;
  logic [31:0] dec_inst;
  logic [31:0] dec_imm;
  logic        wr_class;
  logic        capture;
  decoded_t    dec;
  decoded_t    out_d, out_q;
  logic        valid_d, valid_q;

  assign raw_illegal = is_illegal(in_instruction_i);

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign dec_inst    = in_instruction_i;
  assign dec_illegal = raw_illegal;
`else
  // Substituting the NOP word yields OP_IMM, rd 0, immediate 0 downstream.
  assign dec_inst    = raw_illegal ? NOP_INSN : in_instruction_i;
  assign dec_illegal = 1'b0;
`endif

  imm_gen u_imm_gen (
    .instr_i (dec_inst),
    .imm_o   (dec_imm)
  );

  // field decode by opcode; unknown opcodes fall back to NOP-like fields
  always_comb begin
    dec            = '0;
    dec.pc         = in_pc_i;
    dec.imm        = dec_imm;
    dec.illegal    = dec_illegal;
    dec.cls        = CLS_OP_IMM;
    dec.operation  = ALU_ADD;
    dec.alu_imm_en = 1'b1;
    wr_class       = 1'b0;
    case (dec_inst[6:0])
      OPC_OP: begin
        dec.cls        = CLS_OP;
        dec.rs1        = dec_inst[19:15];
        dec.rs2        = dec_inst[24:20];
        dec.rd         = dec_inst[11:7];
        dec.operation  = {dec_inst[30], dec_inst[14:12]};
        dec.alu_imm_en = 1'b0;
        wr_class       = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.cls       = CLS_OP_IMM;
        dec.rs1       = dec_inst[19:15];
        dec.rd        = dec_inst[11:7];
        dec.operation = {(dec_inst[14:12] == 3'b101) ? dec_inst[30] : 1'b0,
                         dec_inst[14:12]};
        wr_class      = 1'b1;
      end
      OPC_LUI: begin
        dec.cls  = CLS_LUI;
        dec.rd   = dec_inst[11:7];
        wr_class = 1'b1;
      end
      OPC_AUIPC: begin
        dec.cls  = CLS_AUIPC;
        dec.rd   = dec_inst[11:7];
        wr_class = 1'b1;
      end
      OPC_JAL: begin
        dec.cls  = CLS_JAL;
        dec.rd   = dec_inst[11:7];
        wr_class = 1'b1;
      end
      OPC_JALR: begin
        dec.cls  = CLS_JALR;
        dec.rs1  = dec_inst[19:15];
        dec.rd   = dec_inst[11:7];
        wr_class = 1'b1;
      end
      OPC_BRANCH: begin
        dec.cls        = CLS_BRANCH;
        dec.rs1        = dec_inst[19:15];
        dec.rs2        = dec_inst[24:20];
        dec.alu_imm_en = 1'b0;
      end
      OPC_LOAD: begin
        dec.cls  = CLS_LOAD_STORE;
        dec.rs1  = dec_inst[19:15];
        dec.rd   = dec_inst[11:7];
        wr_class = 1'b1;
      end
      OPC_STORE: begin
        dec.cls = CLS_LOAD_STORE;
        dec.rs1 = dec_inst[19:15];
        dec.rs2 = dec_inst[24:20];
      end
      default: begin
        dec.cls = CLS_OP_IMM;
      end
    endcase
    dec.reg_we = wr_class && (dec.rd != 5'd0);
  end

  assign in_ready_o = !valid_q || out_ready_i;
  assign capture    = in_valid_i && in_ready_o && !flush_i;

  // flush beats capture; an idle accept empties the register
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      out_d   = dec;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // output register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign out_valid_o            = valid_q;
  assign out_pc_o               = out_q.pc;
  assign rs1_addr_o             = out_q.rs1;
  assign rs2_addr_o             = out_q.rs2;
  assign rd_addr_o              = out_q.rd;
  assign immediate_data_o       = out_q.imm;
  assign alu_immediate_enable_o = out_q.alu_imm_en;
  assign operation_o            = out_q.operation;
  assign instr_class_o          = out_q.cls;
  assign reg_write_enable_o     = out_q.reg_we;
  assign illegal_o              = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: expected decodes are queued on
// accept and compared while the entry is held at the output.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] immediate_data;
  logic        alu_immediate_enable;
  logic [3:0]  operation;
  logic [2:0]  instr_class;
  logic        reg_write_enable;
  logic        illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .in_valid_i             (in_valid),
    .in_ready_o             (in_ready),
    .in_instruction_i       (in_instruction),
    .in_pc_i                (in_pc),
    .flush_i                (flush),
    .out_valid_o            (out_valid),
    .out_ready_i            (out_ready),
    .out_pc_o               (out_pc),
    .rs1_addr_o             (rs1_addr),
    .rs2_addr_o             (rs2_addr),
    .rd_addr_o              (rd_addr),
    .immediate_data_o       (immediate_data),
    .alu_immediate_enable_o (alu_immediate_enable),
    .operation_o            (operation),
    .instr_class_o          (instr_class),
    .reg_write_enable_o     (reg_write_enable),
    .illegal_o              (illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        aie;
    logic [3:0]  op;
    logic [2:0]  cls;
    logic        rwe;
    logic        ill;
  } exp_t;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];
  exp_t none;

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic aie,
                              input logic [3:0] op, input logic [2:0] cls,
                              input logic rwe, input logic ill);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
    e.aie = aie; e.op = op; e.cls = cls; e.rwe = rwe; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input exp_t e);
    chk("out_pc", out_pc, e.pc);
    chk("rs1_addr", 32'(rs1_addr), 32'(e.rs1));
    chk("rs2_addr", 32'(rs2_addr), 32'(e.rs2));
    chk("rd_addr", 32'(rd_addr), 32'(e.rd));
    chk("immediate_data", immediate_data, e.imm);
    chk("alu_imm_en", 32'(alu_immediate_enable), 32'(e.aie));
    chk("operation", 32'(operation), 32'(e.op));
    chk("instr_class", 32'(instr_class), 32'(e.cls));
    chk("reg_write_en", 32'(reg_write_enable), 32'(e.rwe));
    chk("illegal", 32'(illegal), 32'(e.ill));
  endtask

  // One clock cycle: drive at the falling edge, check, update the scoreboard
  // for what the coming rising edge will do.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input exp_t e);
    logic model_ready;
    @(negedge clk);
    in_valid = v; in_instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    model_ready = (sb.size() == 0) || ordy;
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(model_ready));
    if (sb.size() != 0) check_fields(sb[0]);
    if (fl) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && ordy) void'(sb.pop_front());
      if (v && model_ready) sb.push_back(e);
    end
  endtask

  localparam logic [31:0] I_ADDI  = 32'hFFF00093;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D213;
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_ADDX0 = 32'h00508013;
  localparam logic [31:0] I_ILL7F = 32'h0000007F;
  localparam logic [31:0] I_ILLLO = 32'hFFF00090;

  initial begin
    exp_t e_addi, e_sub, e_srai, e_beq, e_lui, e_sw, e_addx0, e_ill;
    none    = mk(32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
    e_addi  = mk(32'h100, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 4'b0000, 3'd1, 1'b1, 1'b0);
    e_sub   = mk(32'h104, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 4'b1000, 3'd0, 1'b1, 1'b0);
    e_srai  = mk(32'h108, 5'd1, 5'd0, 5'd4, 32'h00000403, 1'b1, 4'b1101, 3'd1, 1'b1, 1'b0);
    e_beq   = mk(32'h10C, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 4'b0000, 3'd6, 1'b0, 1'b0);
    e_lui   = mk(32'h110, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1, 4'b0000, 3'd2, 1'b1, 1'b0);
    e_sw    = mk(32'h114, 5'd1, 5'd2, 5'd0, 32'd8, 1'b1, 4'b0000, 3'd7, 1'b0, 1'b0);
    e_addx0 = mk(32'h118, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 4'b0000, 3'd1, 1'b0, 1'b0);
    e_ill   = mk(32'h11C, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 4'b0000, 3'd1, 1'b0, ILL_EXP);

    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    check_fields(none);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;

    // throughput and decode patterns
    cycle(1'b1, I_ADDI, 32'h100, 1'b1, 1'b0, e_addi);
    cycle(1'b1, I_SUB,  32'h104, 1'b1, 1'b0, e_sub);
    cycle(1'b1, I_SRAI, 32'h108, 1'b1, 1'b0, e_srai);
    cycle(1'b1, I_BEQ,  32'h10C, 1'b1, 1'b0, e_beq);
    // three-cycle stall with LUI waiting
    cycle(1'b1, I_LUI,  32'h110, 1'b0, 1'b0, e_lui);
    cycle(1'b1, I_LUI,  32'h110, 1'b0, 1'b0, e_lui);
    cycle(1'b1, I_LUI,  32'h110, 1'b0, 1'b0, e_lui);
    cycle(1'b1, I_LUI,  32'h110, 1'b1, 1'b0, e_lui);
    cycle(1'b1, I_SW,   32'h114, 1'b1, 1'b0, e_sw);
    cycle(1'b1, I_ADDX0, 32'h118, 1'b1, 1'b0, e_addx0);
    cycle(1'b1, I_ILL7F, 32'h11C, 1'b1, 1'b0, e_ill);
    e_ill.pc = 32'h120;
    cycle(1'b1, I_ILLLO, 32'h120, 1'b1, 1'b0, e_ill);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, none);

    // flush together with in_valid, then flush of a held entry
    e_beq.pc = 32'h124;
    cycle(1'b1, I_BEQ, 32'h124, 1'b1, 1'b1, e_beq);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, none);
    e_sw.pc = 32'h128;
    cycle(1'b1, I_SW, 32'h128, 1'b0, 1'b0, e_sw);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, none);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, none);

    // asynchronous reset during a stall
    e_sub.pc = 32'h12C;
    cycle(1'b1, I_SUB, 32'h12C, 1'b0, 1'b0, e_sub);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, none);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    check_fields(none);
    sb.delete();
    #1 rst = 1'b0;
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, none);
    e_addi.pc = 32'h130;
    cycle(1'b1, I_ADDI, 32'h130, 1'b1, 1'b0, e_addi);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, none);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, none);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction-decode pipeline stage sitting directly upstream of the ALU. Accepts one fetched instruction and its PC per valid/ready handshake and decodes it into register indices, a sign-extended immediate, the ALU immediate-select, the 4-bit ALU operation code and writeback controls. Holds the decoded result in a single output register until the execute stage accepts it. Supports stall and flush.

## Interface
- No parameters; data width is fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instruction  in  32  raw instruction word.
- in_pc  in  32  instruction address.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded instruction held.
- out_ready  in  1  execute accepts this cycle.
- out_pc  out  32  registered PC.
- rs1_addr, rs2_addr, rd_addr  out  5 each  register indices; rs2 is 0 when unused.
- immediate_data  out  32  sign-extended immediate.
- alu_immediate_enable  out  1  ALU second operand is immediate_data.
- operation  out  4  {alt bit, funct3} ALU code.
- instr_class  out  3  OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD_STORE.
- reg_write_enable  out  1  rd is written; forced 0 when rd_addr = 0.
- illegal  out  1  instruction is not a supported encoding.

## Operation
- Decode is combinational from in_instruction; the results are captured into the output register when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is a single-entry register with full throughput; back-to-back transfers occur every cycle while out_ready = 1.
- out_valid: set on capture. Cleared when out_ready && !in_valid. Cleared when flush.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All immediates are sign-extended from inst[31].
- operation:
  - OP: {inst[30], funct3}.
  - OP_IMM: {inst[30] only when funct3 = 101, else 0, funct3}.
  - All other classes: 4'b0000 (ADD).
- alu_immediate_enable is 1 for all classes except OP and BRANCH.
- reg_write_enable is 0 for BRANCH and STORE.
- illegal is set for any of:
  - unknown opcode;
  - OP with funct7 not 0000000 or 0100000;
  - OP with funct7 = 0100000 and funct3 not 000 or 101;
  - shift-immediate with inst[31:25] not 0000000, or not 0100000 for SRAI;
  - inst[1:0] != 11.
- flush wins over capture in the same cycle: out_valid becomes 0 and the input is not accepted. in_ready still reads its normal value; the discarded handshake is the fetch side's responsibility.

## Timing
- Latency: one cycle from in_valid && in_ready to out_valid.
- While out_valid && !out_ready, every output is held stable.
- Reset values:
  - out_valid = 0, out_pc = 0, all decode outputs = 0, illegal = 0.
  - in_ready therefore = 1.
- Reset asserted mid-transfer drops the held instruction. No transfer completes on the cycle reset deasserts with an edge.
- Output data fields are don't-care while out_valid = 0, except under reset.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: illegal is driven as specified and the instruction passes downstream with illegal = 1, for the trap logic.
- DECODE_ILLEGAL_TRAP_EN not defined:
  - illegal is tied to 0;
  - illegal encodings are converted to a NOP: instr_class OP_IMM, rd_addr 0, reg_write_enable 0, immediate 0.

## Structure
- Shared package decode_pkg holds:
  - opcode constants (7-bit);
  - the instr_class enum;
  - the ALU operation codes (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - the NOP encoding 32'h00000013.
- One sub-module: imm_gen. It is combinational and maps instruction to the 32-bit immediate by format.

## Test plan
- ADDI x1, x0, -1 (32'hFFF00093) -> next cycle:
  - out_valid = 1, immediate_data = 32'hFFFFFFFF, operation = 0000, alu_immediate_enable = 1;
  - rd_addr = 1, reg_write_enable = 1.
- SUB x3, x1, x2 (32'h402081B3), then SRAI x4, x1, 3 (32'h4030D213) back-to-back with out_ready = 1:
  - first: operation 1000;
  - second: operation 1101 with immediate low bits = 3;
  - one transfer per cycle.
- BEQ with offset -4 (32'hFE000EE3) -> immediate_data = 32'hFFFFFFFC, reg_write_enable = 0, alu_immediate_enable = 0.
- Hold out_ready = 0 for 3 cycles with in_valid = 1:
  - in_ready = 0;
  - outputs are unchanged;
  - release -> the next instruction is captured on the same edge as the old one is accepted.
- flush asserted together with in_valid → next cycle out_valid = 0. Async rst pulse mid-stall → out_valid = 0 immediately, without waiting for a clock edge.
- 32'h0000007F with DECODE_ILLEGAL_TRAP_EN → illegal = 1. Without the macro → NOP outputs, illegal = 0.
